rx_frame_check: RTL

RX_FRAME_CHECK -- requirements
Module: rx_frame_check

---
 rtl/rx_frame_check.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/rx_frame_check.sv
// rx_frame_check: UART-style receive framer. Consumes the sampler's start strobe and voted bit
// strobes, assembles LSB-first data, and checks the start, parity and stop bits. It reports each
// frame with one-cycle pulses and counts errored frames in a saturating counter.
//
// Ports:
//   CLK, RST             clock (rising edge), asynchronous active-low reset
//   frame_start          falling edge seen on the line; honoured only in IDLE
//   bit_valid            strobe qualifying sampled_bit
//   sampled_bit          majority-voted bit value
//   par_en, par_typ      parity enable, 0 = even / 1 = odd (latched at frame start)
//   stop_bits            0 = one stop bit, 1 = two (latched at frame start)
//   err_clr              synchronous clear of err_cnt, wins over an increment
//   P_DATA               received data word
//   data_valid           one-cycle pulse: error-free frame, P_DATA valid
//   frame_done           one-cycle pulse at the end of every frame
//   strt_glitch, par_err, stp_err  error flags, held until the next accepted frame_start
//   busy                 state is not IDLE
//   err_cnt              saturating count of errored frames
module rx_frame_check #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ERR_CNT_WIDTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     frame_start,
    input  logic                     bit_valid,
    input  logic                     sampled_bit,
    input  logic                     par_en,
    input  logic                     par_typ,
    input  logic                     stop_bits,
    input  logic                     err_clr,
    output logic [DATA_WIDTH-1:0]    P_DATA,
    output logic                     data_valid,
    output logic                     frame_done,
    output logic                     strt_glitch,
    output logic                     par_err,
    output logic                     stp_err,
    output logic                     busy,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

    localparam int unsigned     IdxW    = $clog2(DATA_WIDTH);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop1, StStop2, StDone
    } state_e;

    state_e                   state_q, state_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic [IdxW-1:0]          bit_idx_q, bit_idx_d;
    logic                     par_en_q, par_en_d;
    logic                     par_typ_q, par_typ_d;
    logic                     stop_bits_q, stop_bits_d;
    logic                     strt_glitch_q, strt_glitch_d;
    logic                     par_err_q, par_err_d;
    logic                     stp_err_q, stp_err_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic                     any_err;

    assign any_err = strt_glitch_q | par_err_q | stp_err_q;

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; only IDLE and DONE advance without bit_valid
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (frame_start) state_d = StStart;
            StStart:  if (bit_valid) state_d = sampled_bit ? StDone : StData;
            StData:   if (bit_valid && (bit_idx_q == LastIdx)) begin
                          state_d = par_en_q ? StParity : StStop1;
                      end
            StParity: if (bit_valid) state_d = StStop1;
            StStop1:  if (bit_valid) state_d = stop_bits_q ? StStop2 : StDone;
            StStop2:  if (bit_valid) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy       = (state_q != StIdle);
        frame_done = (state_q == StDone);
        data_valid = (state_q == StDone) && !any_err;
    end

    // Datapath next-state
    always_comb begin
        data_d        = data_q;
        bit_idx_d     = bit_idx_q;
        par_en_d      = par_en_q;
        par_typ_d     = par_typ_q;
        stop_bits_d   = stop_bits_q;
        strt_glitch_d = strt_glitch_q;
        par_err_d     = par_err_q;
        stp_err_d     = stp_err_q;
        err_cnt_d     = err_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (frame_start) begin
                    par_en_d      = par_en;
                    par_typ_d     = par_typ;
                    stop_bits_d   = stop_bits;
                    strt_glitch_d = 1'b0;
                    par_err_d     = 1'b0;
                    stp_err_d     = 1'b0;
                    bit_idx_d     = '0;
                end
            end
            StStart: begin
                if (bit_valid) begin
                    strt_glitch_d = sampled_bit;
                    bit_idx_d     = '0;
                end
            end
            StData: begin
                if (bit_valid) begin
                    data_d[bit_idx_q] = sampled_bit;
                    bit_idx_d         = bit_idx_q + IdxW'(1);
                end
            end
            // Even parity expects XOR of data; odd expects its inverse
            StParity: if (bit_valid) par_err_d = sampled_bit ^ (^data_q) ^ par_typ_q;
            StStop1:  if (bit_valid && !sampled_bit) stp_err_d = 1'b1;
            StStop2:  if (bit_valid && !sampled_bit) stp_err_d = 1'b1;
            default:  ;
        endcase

        if (err_clr) begin
            err_cnt_d = '0;
        end else if ((state_q == StDone) && any_err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_q        <= '0;
            bit_idx_q     <= '0;
            par_en_q      <= 1'b0;
            par_typ_q     <= 1'b0;
            stop_bits_q   <= 1'b0;
            strt_glitch_q <= 1'b0;
            par_err_q     <= 1'b0;
            stp_err_q     <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            data_q        <= data_d;
            bit_idx_q     <= bit_idx_d;
            par_en_q      <= par_en_d;
            par_typ_q     <= par_typ_d;
            stop_bits_q   <= stop_bits_d;
            strt_glitch_q <= strt_glitch_d;
            par_err_q     <= par_err_d;
            stp_err_q     <= stp_err_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign P_DATA      = data_q;
    assign strt_glitch = strt_glitch_q;
    assign par_err     = par_err_q;
    assign stp_err     = stp_err_q;
    assign err_cnt     = err_cnt_q;

endmodule
